regfile_mp_sb: RTL
==================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port MIPS register file with write-through bypass and a per-register
//  busy scoreboard. Serves NREAD decode-stage read ports, NWRITE writeback ports and one
//  issue port that marks destination registers pending. rbusy tells decode to stall.
//  Drop-in successor to the single-write, dual-read file in the flowCPU decode stage.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   register address width; NREG = 2**ADDR_W registers
//  NREAD    4   number of read ports
//  NWRITE   2   number of write ports; higher index has priority
//  BYPASS   1   1 = same-cycle write data is forwarded to reads; 0 = reads see array only
// PORTS
//  clk       in   1                clock, all state updates on posedge
//  rst       in   1                synchronous reset, active-high
//  re        in   NREAD            per-port read enable
//  raddr     in   NREAD*ADDR_W     read addresses, port i at [i*ADDR_W +: ADDR_W]
//  rdata     out  NREAD*DATA_W     read data, port i at [i*DATA_W +: DATA_W]
//  rbusy     out  NREAD            1 = register at raddr[i] has an outstanding producer
//  we        in   NWRITE           per-port write enable
//  waddr     in   NWRITE*ADDR_W    write addresses
//  wdata     in   NWRITE*DATA_W    write data
//  iss_valid in   1                issue of an instruction that will write iss_addr
//  iss_addr  in   ADDR_W           destination register of issuing instruction
//  flush     in   1                pipeline flush: clear every busy bit
//  busy_cnt  out  ADDR_W+1         number of registers whose busy bit is set
// BEHAVIOUR
//  Reset: on posedge with rst=1 all NREG registers <= 0, all busy bits <= 0, busy_cnt <= 0.
//   While rst=1, rdata = 0 and rbusy = 0 on every port (combinational gating).
//  Register 0: never written, never busy; read of address 0 returns 0, rbusy 0.
//  Write: on posedge, for each register the highest-index port j with we[j]=1 and
//   waddr[j]==reg (reg!=0) writes wdata[j]; lower-index ports to same reg are dropped.
//  Read (combinational, 0-cycle): port i with re[i]=0 -> rdata=0, rbusy=0.
//   re[i]=1, BYPASS=1 and some we[j] hits raddr[i] (!=0): rdata = wdata of highest such j.
//   Otherwise rdata = array[raddr[i]]. All NREAD ports independent; any address aliasing OK.
//  Scoreboard (one bit per register, updated on posedge, rst highest priority):
//   flush=1: all busy <= 0, then iss_valid still applies (issuing instr survives flush).
//   clear: any we[j]=1 with waddr[j]=r clears busy[r].
//   set: iss_valid=1 and iss_addr=r!=0 sets busy[r]; set wins over same-cycle clear
//    (new producer outstanding). iss_addr=0 ignored.
//  rbusy[i] = re[i] & busy[raddr[i]] & ~(BYPASS & same-cycle write hit on raddr[i]);
//   bypassed data satisfies the hazard even if busy is still set this cycle.
//  busy_cnt: registered population count of busy bits, valid the cycle after update;
//   range 0..NREG-1, never wraps.
//  No handshake beyond the above; block never stalls, caller stalls on rbusy.
// TESTING
//  1 rst=1 two cycles after writing r5=0xDEADBEEF -> rdata(r5)=0, busy_cnt=0 after release.
//  2 we[0]=we[1]=1, waddr both 7, wdata 0x11/0x22 -> next cycle read r7 = 0x22; same-cycle
//    read of r7 with BYPASS=1 = 0x22, with BYPASS=0 = old value.
//  3 write r0=0xFFFFFFFF, iss_addr=0 -> read r0 = 0, rbusy=0, busy_cnt unchanged.
//  4 issue r3, then r4 -> busy_cnt=2; read r3 rbusy=1; write r3 -> rbusy 0 same cycle
//    (bypass), busy_cnt=1 next cycle.
//  5 iss r9 and we r9 same cycle -> busy[9] stays 1; flush with iss r2 -> only r2 busy, cnt=1.
//  6 NREAD=4 all reading r12 (=0x0000ABCD) with re=4'b1010 -> ports 1,3 = 0xABCD, ports 0,2 = 0.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port MIPS register file with write-through bypass and a per-register busy scoreboard.
// Register 0 is hardwired to zero and never busy; higher-index write ports win on conflicts.
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 4,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD-1:0]         re,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  output logic [NREAD-1:0]         rbusy,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  logic [ADDR_W-1:0] rd_a;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_byp;

  // Ascending port order: the last non-blocking write to a register wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      for (int unsigned j = 0; j < NWRITE; j++) begin
        if (we[j] && waddr[j*ADDR_W +: ADDR_W] != '0)
          mem[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  // Flush first, then clears, then issue: the issuing producer survives both.
  always_comb begin
    busy_nxt = flush ? '0 : busy;
    for (int unsigned j = 0; j < NWRITE; j++) begin
      if (we[j]) busy_nxt[waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (iss_valid && iss_addr != '0) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int unsigned r = 0; r < NREG; r++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[r]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    rdata  = '0;
    rbusy  = '0;
    rd_a   = '0;
    rd_hit = 1'b0;
    rd_byp = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      rd_a   = raddr[i*ADDR_W +: ADDR_W];
      rd_hit = 1'b0;
      rd_byp = '0;
      for (int unsigned j = 0; j < NWRITE; j++) begin
        if (we[j] && waddr[j*ADDR_W +: ADDR_W] == rd_a) begin
          rd_hit = 1'b1;
          rd_byp = wdata[j*DATA_W +: DATA_W];
        end
      end
      if (re[i] && !rst && rd_a != '0) begin
        if (BYPASS != 0 && rd_hit) begin
          rdata[i*DATA_W +: DATA_W] = rd_byp;
          rbusy[i]                  = 1'b0;
        end else begin
          rdata[i*DATA_W +: DATA_W] = mem[rd_a];
          rbusy[i]                  = busy[rd_a];
        end
      end
    end
  end

endmodule
